// File: rtl/logic16_arbiter.sv
// rtl/logic16_arbiter.sv - round-robin arbiter sharing one 16-bit AND/OR/XOR/NOT unit among four requesters
module logic16_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   a_in,
    input  logic [4*WIDTH-1:0]   b_in,
    input  logic [7:0]           op_in,
    output logic [3:0]           gnt,
    output logic                 busy,
    output logic [WIDTH-1:0]     out,
    output logic [1:0]           out_id,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    logic [1:0]       r_state;
    logic [3:0]       r_gnt;
    logic [1:0]       r_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [1:0]       r_idx;
    logic [WIDTH-1:0] r_out;
    logic [1:0]       r_out_id;
    logic             r_out_valid;

    logic [1:0]       w_win;
    logic             w_any;
    logic [WIDTH-1:0] w_result;

    // Search starts one past the last winner, so the previous owner ends up lowest priority.
    always_comb begin
        w_win = r_last;
        w_any = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_any && req[r_last + 2'(k)]) begin
                w_win = r_last + 2'(k);
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_result = '0;
        case (r_op)
            OP_AND:  w_result = r_a & r_b;
            OP_OR:   w_result = r_a | r_b;
            OP_XOR:  w_result = r_a ^ r_b;
            default: w_result = ~r_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= 4'b0000;
            r_last      <= 2'd3;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 2'b00;
            r_idx       <= 2'd0;
            r_out       <= '0;
            r_out_id    <= 2'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= 4'b0001 << w_win;
                        r_a     <= a_in[w_win*WIDTH +: WIDTH];
                        r_b     <= b_in[w_win*WIDTH +: WIDTH];
                        r_op    <= op_in[2*w_win +: 2];
                        r_idx   <= w_win;
                        r_last  <= w_win;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_out       <= w_result;
                    r_out_id    <= r_idx;
                    r_out_valid <= 1'b1;
                    r_gnt       <= 4'b0000;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    // out keeps its value after the handshake; only the valid flag drops.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_gnt       <= 4'b0000;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign busy      = (r_state != S_IDLE);
    assign out       = r_out;
    assign out_id    = r_out_id;
    assign out_valid = r_out_valid;

endmodule
